// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle between N valid/ready producers, the channel merger and one consumer.
interface mux_nx1_rr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) ();
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   select;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [SEL_W-1:0]   out_chan;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// N-to-1 channel merger with manual-select or round-robin grant and a one-entry
// registered output stage that holds its word under back-pressure.
module mux_nx1_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_nx1_rr_if.slave  bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             transfer;
    logic [N-1:0]     in_ready_c;

    assign load_en = !out_valid_q || bus.out_ready;

    // Grant: manual picks a valid selected channel; round-robin scans ptr..N-1 then 0..ptr-1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!bus.mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (bus.select == SEL_W'(k) && bus.in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!grant_vld && bus.in_valid[k] && ptr_q <= SEL_W'(k)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
            for (int unsigned k = 0; k < N; k++) begin
                if (!grant_vld && bus.in_valid[k] && ptr_q > SEL_W'(k)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end
    end

    // Ready is offered only when the output register can load; out-of-range select matches no k.
    always_comb begin
        in_ready_c = '0;
        grant_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.mode) begin
                in_ready_c[k] = !rst && load_en && grant_vld && (grant_idx == SEL_W'(k));
            end else begin
                in_ready_c[k] = !rst && load_en && (bus.select == SEL_W'(k));
            end
            if (grant_idx == SEL_W'(k)) begin
                grant_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = !rst && load_en && grant_vld;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = transfer;
            if (transfer) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                ptr_d      = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed vector bench for mux_nx1_rr: a 4-channel instance driven from a table plus
// hand sequences for reset, mid-stream reset and a 6-channel select boundary.
module tb_mux_nx1_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_rr_if #(.WIDTH(8), .N(4), .SEL_W(2)) bus4 ();
    mux_nx1_rr_if #(.WIDTH(8), .N(6), .SEL_W(3)) bus6 ();

    mux_nx1_rr #(.WIDTH(8), .N(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mux_nx1_rr #(.WIDTH(8), .N(6), .SEL_W(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    typedef struct packed {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_chan;
        logic [7:0]  exp_data;
    } vec_t;

    localparam logic [31:0] D   = 32'h4332_2110;
    localparam logic [31:0] DAB = 32'h4332_AB10;

    vec_t vecs [20];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic ordy, input logic [3:0] er,
                                input logic eov, input logic [1:0] ec, input logic [7:0] ed);
        vec_t r;
        r.mode = m; r.sel = s; r.valid = v; r.data = d; r.oready = ordy;
        r.exp_rdy = er; r.exp_ov = eov; r.exp_chan = ec; r.exp_data = ed;
        return r;
    endfunction

    task automatic drive4(input logic m, input logic [1:0] s, input logic [3:0] v,
                          input logic [31:0] d, input logic ordy);
        bus4.mode = m; bus4.select = s; bus4.in_valid = v; bus4.in_data = d; bus4.out_ready = ordy;
    endtask

    task automatic chk_out4(input string tag, input logic ov, input logic [1:0] ch, input logic [7:0] dt);
        chk({tag, "_ov"},   32'(bus4.out_valid), 32'(ov));
        chk({tag, "_chan"}, 32'(bus4.out_chan),  32'(ch));
        chk({tag, "_data"}, 32'(bus4.out_data),  32'(dt));
    endtask

    initial begin
        // round-robin, all valid: 0,1,2,3,0,1 with no bubbles
        vecs[0]  = mk(1, 0, 4'hF, D,   1, 4'b0001, 1, 0, 8'h10);
        vecs[1]  = mk(1, 0, 4'hF, D,   1, 4'b0010, 1, 1, 8'h21);
        vecs[2]  = mk(1, 0, 4'hF, D,   1, 4'b0100, 1, 2, 8'h32);
        vecs[3]  = mk(1, 0, 4'hF, D,   1, 4'b1000, 1, 3, 8'h43);
        vecs[4]  = mk(1, 0, 4'hF, D,   1, 4'b0001, 1, 0, 8'h10);
        vecs[5]  = mk(1, 0, 4'hF, D,   1, 4'b0010, 1, 1, 8'h21);
        // sparse 1010 from ptr=2, then alternating 1/3
        vecs[6]  = mk(1, 0, 4'hA, D,   1, 4'b1000, 1, 3, 8'h43);
        vecs[7]  = mk(1, 0, 4'hA, D,   1, 4'b0010, 1, 1, 8'h21);
        vecs[8]  = mk(1, 0, 4'hA, D,   1, 4'b1000, 1, 3, 8'h43);
        vecs[9]  = mk(1, 0, 4'hA, D,   1, 4'b0010, 1, 1, 8'h21);
        // manual select
        vecs[10] = mk(0, 2, 4'hF, D,   1, 4'b0100, 1, 2, 8'h32);
        vecs[11] = mk(0, 2, 4'hF, D,   1, 4'b0100, 1, 2, 8'h32);
        vecs[12] = mk(0, 3, 4'hF, D,   1, 4'b1000, 1, 3, 8'h43);
        vecs[13] = mk(0, 1, 4'h0, D,   1, 4'b0010, 0, 3, 8'h43);
        vecs[14] = mk(1, 0, 4'h0, D,   1, 4'b0000, 0, 3, 8'h43);
        // back-pressure on 0xAB from channel 1, mode switch while held, then same-cycle reload
        vecs[15] = mk(1, 0, 4'h2, DAB, 0, 4'b0010, 1, 1, 8'hAB);
        vecs[16] = mk(1, 0, 4'hF, D,   0, 4'b0000, 1, 1, 8'hAB);
        vecs[17] = mk(1, 0, 4'hF, D,   0, 4'b0000, 1, 1, 8'hAB);
        vecs[18] = mk(0, 2, 4'hF, D,   0, 4'b0000, 1, 1, 8'hAB);
        vecs[19] = mk(1, 0, 4'hF, D,   1, 4'b0100, 1, 2, 8'h32);

        rst = 1'b1;
        drive4(1, 0, 4'hF, D, 1);
        bus6.mode = 1'b0; bus6.select = '0; bus6.in_valid = '0; bus6.in_data = '0; bus6.out_ready = 1'b1;

        #1;
        chk("rst_rdy_pre", 32'(bus4.in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus4.in_ready), 32'h0);
        chk_out4("rst", 1'b0, 2'd0, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive4(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].oready);
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(bus4.in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk_out4($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_chan, vecs[i].exp_data);
        end

        // reset while a word is held: discards it and returns ptr to 0
        drive4(1, 0, 4'hF, D, 0);
        #1;
        chk("hold_rdy", 32'(bus4.in_ready), 32'h0);
        drive4(1, 0, 4'hF, D, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rdy", 32'(bus4.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_out4("midrst", 1'b0, 2'd0, 8'h00);
        drive4(1, 0, 4'hF, D, 1);
        #1;
        chk("post_rst_rdy", 32'(bus4.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk_out4("post_rst", 1'b1, 2'd0, 8'h10);

        // six channels: select 5 is the top channel, select 6 is out of range
        bus6.in_data  = 48'h5A44_3322_1100;
        bus6.mode     = 1'b0;
        bus6.select   = 3'd5;
        bus6.in_valid = 6'b100000;
        #1;
        chk("n6_sel5_rdy", 32'(bus6.in_ready), 32'b100000);
        @(posedge clk);
        #1;
        chk("n6_sel5_ov",   32'(bus6.out_valid), 32'h1);
        chk("n6_sel5_chan", 32'(bus6.out_chan),  32'h5);
        chk("n6_sel5_data", 32'(bus6.out_data),  32'h5A);
        bus6.select   = 3'd6;
        bus6.in_valid = 6'b111111;
        #1;
        chk("n6_sel6_rdy", 32'(bus6.in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("n6_sel6_ov",   32'(bus6.out_valid), 32'h0);
        chk("n6_sel6_chan", 32'(bus6.out_chan),  32'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 multiplexer with a registered, handshaked output stage and two selection modes: external select and round-robin arbitration. It generalises the combinational 2:1 mux into a channel merger that sits between N valid/ready producers and a single consumer. Data is captured into a one-entry output register so that back-pressure holds the output stable. The block reports which channel each output word came from.

## Interface

Parameters:
- WIDTH, 8, data width per channel
- N, 4, number of input channels (N >= 2)
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= N

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset. Synchronous and active-high; one clock, sampled on the rising edge of clk.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- mode  input  1  0 = manual (select), 1 = round-robin
- select  input  SEL_W  channel index in manual mode, ignored in round-robin mode
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered valid
- out_chan  output  SEL_W  source channel of out_data
- out_ready  input  1  consumer ready

## Operation

- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is 1.
- Grant, combinational, at most one channel per cycle:
  - Manual mode: g = select if select < N and in_valid[select]; otherwise no grant.
  - Round-robin mode: g = first k with in_valid[k], scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready[k]:
  - Manual mode: in_ready[k] = load_en && (k == select). It may be 1 while in_valid[k] is 0.
  - Round-robin mode: in_ready[k] = load_en && (k == g), so it is asserted only on the granted channel.
  - If select >= N, all in_ready bits are 0.
- Transfer on channel k: in_valid[k] && in_ready[k] at a rising edge. On transfer:
  - out_data <= channel k data
  - out_chan <= k
  - out_valid <= 1
- Output side:
  - If load_en is 1 and no transfer occurs, out_valid <= 0. out_data and out_chan keep their last value.
  - If out_valid && !out_ready, out_data, out_chan and out_valid hold unchanged.
- Round-robin pointer ptr (SEL_W bits):
  - On a transfer in either mode, ptr <= (k == N-1) ? 0 : k+1, wrapping at N.
  - Without a transfer, ptr holds.
  - ptr is not reset by mode changes.
- Mode and select may change on any cycle. A change affects only the next grant and never disturbs a held output word.

## Timing

- Reset values, taking effect at the first rising edge with rst = 1: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
- While rst = 1, in_ready = 0 on all channels.
- Reset mid-operation discards any held output word without completing a handshake.
- Latency: a word transferred at edge t appears on out_data/out_valid after edge t.
- Throughput: one word per cycle when out_ready stays at 1.
- Simultaneous out_ready = 1 and a new transfer at the same edge: the old word is consumed and the new word is loaded. out_valid stays 1 with no bubble.
- Back-pressure: with out_valid = 1 and out_ready = 0, every in_ready bit is 0.
- Round-robin fairness: with all channels continuously valid, grants cycle 0, 1, ..., N-1, 0, ... Each channel is granted exactly once per N transfers.
- No combinational path from in_valid to out_*. The only combinational paths are in_valid/select/mode/out_ready/out_valid -> in_ready.

## Test plan

- Reset: drive rst = 1 for 2 cycles with all in_valid = 1. Required: out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0000. The first grant after release is channel 0 in round-robin mode.
- Manual mode: select = 2, in_valid = 1111, channel data 0x10, 0x21, 0x32, 0x43, out_ready = 1. Required: in_ready = 0100 and out_data = 0x32 every cycle with out_chan = 2. Setting select = 5 with N = 6 selects channel 5; with N = 4 and select = 3 the output shows channel 3.
- Round-robin, all valid, out_ready = 1, N = 4. Required: out_chan sequence 0, 1, 2, 3, 0, 1 on consecutive cycles. The sequence wraps and has no bubbles.
- Round-robin sparse: in_valid = 1010 with ptr = 0. Required: grants are 1, 3, 1, 3. After a channel 3 grant, ptr = 0.
- Back-pressure: out_ready = 0 for 3 cycles after a word 0xAB from channel 1 is loaded. Required: out_data stays 0xAB, out_valid stays 1 and in_ready = 0000. When out_ready returns to 1, the next word loads in the same cycle.
- Mode switch and reset mid-stream: switch mode from 1 to 0 while out_valid = 1 and out_ready = 0. Required: the held word is unchanged. Assert rst for 1 cycle while a word is held. Required: out_valid = 0 and ptr = 0 on the next cycle.
